// File: rtl/atm_pkg.sv
// Shared ATM protocol definitions: state codes, digit width, SEG patterns, PIN check.
package atm_pkg;

  localparam int DBITS      = 3;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INSERT = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } atm_state_t;

  // Active-high segments {g,f,e,d,c,b,a} for the values 0..6.
  function automatic logic [6:0] seg_pattern(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'b0111111;
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1011011;
      3'd3:    s = 7'b1001111;
      3'd4:    s = 7'b1100110;
      3'd5:    s = 7'b1101101;
      3'd6:    s = 7'b1111101;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // The ATM only detects digit changes, so zeros and repeated neighbours are unsendable.
  function automatic logic pin_valid(input logic [MAX_DIGITS*DBITS-1:0] p, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && p[i*DBITS +: DBITS] == '0) ok = 1'b0;
    end
    for (int i = 1; i < MAX_DIGITS; i++) begin
      if (i < n && p[i*DBITS +: DBITS] == p[(i-1)*DBITS +: DBITS]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/atm_cycle_timer.sv
// Loadable down-counter; tc is high while the count is zero and the count never wraps.
module atm_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk_2,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/atm_pin_sender.sv
// Scripted ATM customer: inserts card, presents PIN digits for fixed hold times, awaits response.
// All outputs registered; responses only sampled in WAIT, abort ends any active session next cycle.
module atm_pin_sender
  import atm_pkg::*;
#(
  parameter int NDIGITS        = 3,
  parameter int DBITS          = atm_pkg::DBITS,
  parameter int SETTLE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NDIGITS*DBITS-1:0]   pin,
  input  logic                       dinheiro,
  input  logic                       destruiu,
  output logic                       card,
  output logic [DBITS-1:0]           code,
  output logic                       busy,
  output logic                       done,
  output logic                       success,
  output logic                       fail,
  output logic                       timeout,
  output logic [2:0]                 state_o
);

  localparam int MAXC = (SETTLE_CYCLES > HOLD_CYCLES)
                      ? ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES)
                      : ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES);
  localparam int TW   = $clog2(MAXC + 1);
  localparam int IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PADW = MAX_DIGITS*atm_pkg::DBITS - NDIGITS*DBITS;

  atm_state_t               state;
  logic [NDIGITS*DBITS-1:0] pin_r;
  logic [IW-1:0]            idx;
  logic [IW-1:0]            idx_nxt;
  logic                     start_q;
  logic                     armed;
  logic                     start_edge;
  logic                     last_digit;
  logic                     pin_ok;
  logic [MAX_DIGITS*atm_pkg::DBITS-1:0] pin_ext;

  logic          t_clr;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          tc;

  // armed blocks a start level that was already high when reset released.
  assign start_edge = start & ~start_q & armed;
  assign idx_nxt    = idx + 1'b1;
  assign last_digit = (idx == IW'(NDIGITS-1));
  assign pin_ext    = {{PADW{1'b0}}, pin};
  assign pin_ok     = pin_valid(pin_ext, NDIGITS);
  assign state_o    = state;

  always_comb begin
    t_clr  = 1'b0;
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      ST_IDLE: begin
        if (start_edge && pin_ok) begin
          t_load = 1'b1;
          t_val  = TW'(SETTLE_CYCLES - 1);
        end
      end
      ST_INSERT: begin
        if (abort) t_clr = 1'b1;
        else if (tc) begin
          t_load = 1'b1;
          t_val  = TW'(HOLD_CYCLES - 1);
        end
      end
      ST_SEND: begin
        if (abort) t_clr = 1'b1;
        else if (tc) begin
          t_load = 1'b1;
          t_val  = last_digit ? TW'(TIMEOUT_CYCLES - 1) : TW'(HOLD_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (abort || destruiu || dinheiro || tc) t_clr = 1'b1;
      end
      default: t_clr = 1'b1;
    endcase
  end

  atm_cycle_timer #(.W(TW)) u_timer (
    .clk_2    (clk_2),
    .reset    (reset),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_val),
    .tc       (tc)
  );

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pin_r   <= '0;
      idx     <= '0;
      start_q <= 1'b0;
      armed   <= 1'b0;
      card    <= 1'b0;
      code    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      success <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            pin_r <= pin;
            idx   <= '0;
            if (pin_ok) begin
              state <= ST_INSERT;
              card  <= 1'b1;
              code  <= '0;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              fail  <= 1'b1;
            end
          end
        end
        ST_INSERT, ST_SEND, ST_WAIT: begin
          if (abort) begin
            state <= ST_DONE;
            card  <= 1'b0;
            code  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            fail  <= 1'b1;
          end else if (state == ST_WAIT) begin
            if (destruiu || dinheiro || tc) begin
              state   <= ST_DONE;
              card    <= 1'b0;
              code    <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              fail    <= destruiu;
              success <= ~destruiu & dinheiro;
              timeout <= ~destruiu & ~dinheiro;
            end
          end else if (tc) begin
            if (state == ST_INSERT) begin
              state <= ST_SEND;
              idx   <= '0;
              code  <= pin_r[DBITS-1:0];
            end else if (last_digit) begin
              state <= ST_WAIT;
            end else begin
              idx  <= idx_nxt;
              code <= pin_r[idx_nxt*DBITS +: DBITS];
            end
          end
        end
        default: begin
          if (!start) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            success <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/atm_pin_sender.md
Name: atm_pin_sender

Overview:
- Customer-side initiator for the ATM card/PIN protocol. It drives `card` and the 3-bit `code` bus into the ATM controller.
- It presents a stored PIN one digit at a time, holding each digit for a fixed number of cycles, then waits for the ATM's cash or destroy response.
- Used on the board top as a scripted customer for self-test: PIN from SWI, results on LED/SEG.

Parameters:
- NDIGITS, 3, number of PIN digits sent per session.
- DBITS, 3, width of one digit and of `code`.
- SETTLE_CYCLES, 2, cycles with card=1, code=0 before the first digit.
- HOLD_CYCLES, 4, cycles each digit is held on `code` (must be >=1).
- TIMEOUT_CYCLES, 16, maximum cycles waiting for the ATM response after the last digit.

Ports:
- clk_2  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; rising edge (registered compare) begins a session while IDLE.
- abort  input  1  synchronous; ends any active session.
- pin  input  NDIGITS*DBITS  PIN; digit 0 in bits [DBITS-1:0]; captured on start.
- dinheiro  input  1  ATM response: cash released.
- destruiu  input  1  ATM response: card destroyed.
- card  output  1  card-inserted line to the ATM.
- code  output  DBITS  digit currently presented.
- busy  output  1  session in progress.
- done  output  1  session finished; result valid.
- success  output  1  ATM answered dinheiro.
- fail  output  1  ATM answered destruiu, or PIN rejected, or aborted.
- timeout  output  1  no response within TIMEOUT_CYCLES.
- state_o  output  3  current state encoding, for SEG display.

Behaviour:
- Reset (async): state=IDLE; card=0, code=0, busy=0, done=0, success=0, fail=0, timeout=0; digit index=0; timer=0; start-edge register=0.
- All outputs are registered and change only on posedge clk_2, except under reset.
- States:
  - IDLE: all outputs 0. On a start rising edge, capture pin and validate it.
    - PIN invalid if any digit==0 or two consecutive digits are equal (the ATM cannot see a digit change).
    - Invalid -> DONE with fail=1, card never raised.
    - Valid -> INSERT.
  - INSERT: card=1, code=0 for SETTLE_CYCLES cycles -> SEND with idx=0.
  - SEND: card=1, code=digit[idx] for HOLD_CYCLES cycles. No 0 gap between digits; code switches directly to the next digit.
    - idx==NDIGITS-1 at hold end -> WAIT.
    - Otherwise idx+1 and stay in SEND.
  - WAIT: card=1, code holds the last digit. Timer counts 0..TIMEOUT_CYCLES-1.
    - destruiu=1 -> DONE, fail=1.
    - Else dinheiro=1 -> DONE, success=1.
    - Else timer expiry -> DONE, timeout=1.
  - DONE: card=0, code=0, busy=0, done=1, and the result flag from the exiting state holds. Return to IDLE (flags cleared) when start is low.
- busy=1 in INSERT, SEND and WAIT.
- Responses are sampled only in WAIT; dinheiro/destruiu seen in INSERT or SEND are ignored.
- Simultaneous dinheiro and destruiu: destruiu wins.
- abort=1 in INSERT, SEND or WAIT: next cycle DONE with fail=1, card=0. abort in IDLE or DONE has no effect. abort has priority over responses in the same cycle.
- start held high or re-pulsed while busy/done: ignored; only a new rising edge in IDLE starts a session.
- Reset mid-session: card and code drop to 0 immediately (async), no result reported.
- Timer: $clog2(max(SETTLE,HOLD,TIMEOUT)+1) bits, cleared on each state or digit change. Never wraps; the terminal count forces the transition.
- state_o encoding: IDLE=0, INSERT=1, SEND=2, WAIT=3, DONE=4.

Decomposition:
- Shared package atm_pkg:
  - state enum (encoding above), shared with the ATM controller's state codes;
  - DBITS constant;
  - 7-segment patterns for 0..6;
  - function pin_valid(pin).
- One sub-module, atm_cycle_timer: a loadable down-counter with clear and terminal-count output. It is used for settle, hold and timeout.

Test Plan:
- pin={7,3,1}, HOLD=4, SETTLE=2, dinheiro pulsed 3 cycles into WAIT -> card high 2 cycles with code=0, then code=1,3,7 each for 4 cycles; done=1, success=1, card=0 on the following edge.
- Same PIN against the ATM model with PIN 1-3-5 -> ATM raises destruiu; fail=1, success=0, done=1.
- No response for 16 cycles in WAIT -> timeout=1 after exactly TIMEOUT_CYCLES, card=0.
- pin={3,3,1} and pin={7,0,1} -> DONE with fail=1 one cycle after start; card stays 0 throughout.
- abort asserted on the 2nd cycle of digit 3 -> next edge card=0, code=0, fail=1; dinheiro and destruiu asserted together in WAIT -> fail=1.
- reset asserted mid-SEND (code=3) -> card/code 0 without waiting for a clock edge. After release, start held high gives no new session until it goes low and high again.
